// File: rtl/iic_frame_ctrl.sv
// iic_frame_ctrl
// IIC slave frame sequencer for an EEPROM-style interface. Runs on the bit
// clock (one rising edge per SCL bit). It tracks the byte position (command,
// address, data), counts bits 8..0 with 0 being the ack slot, and drives the
// memory read/write strobes.
//
// Build option: define IIC_ONE_BYTE_ADDR_EN for devices with a single address
// byte. The high address byte is then skipped, iic_mem_addr[15:8] reads 0 and
// read prefetch wraps at 8 bits.
module iic_frame_ctrl #(
    parameter logic [6:0] TCMD_ID   = 7'h7C,
    parameter int         PAGE_BITS = 5
) (
    input  logic        iic_clk_c,
    input  logic        iic_frm_rst_n,
    input  logic        iic_sda_in,
    input  logic        iic_start,
    input  logic        iic_stop,
    input  logic [6:0]  iic_dev_id,
    input  logic        iic_hwp_val,
    output logic [2:0]  iic_curr_state,
    output logic [3:0]  iic_bit_cnt,
    output logic        iic_bitcnt_is_0,
    output logic        iic_cmd_user_val,
    output logic        iic_tcmd_val,
    output logic [15:0] iic_mem_addr,
    output logic        iic_wr_en,
    output logic [7:0]  iic_wr_data,
    output logic        iic_rd_en
);

`ifdef IIC_ONE_BYTE_ADDR_EN
    localparam bit ONE_BYTE_ADDR = 1'b1;
`else
    localparam bit ONE_BYTE_ADDR = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_CMD     = 3'b001,
        ST_ADDR_HB = 3'b010,
        ST_ADDR_LB = 3'b011,
        ST_DAT_RD  = 3'b100,
        ST_WAIT    = 3'b101,
        ST_BYTE_WR = 3'b110,
        ST_PAGE_WR = 3'b111
    } state_e;

    state_e      state_q;
    logic [3:0]  bit_cnt_q;
    // Only 7 bits are kept: the 8th bit of a byte is the live SDA sample.
    logic [6:0]  shift_q;
    logic        user_val_q;
    logic        tcmd_val_q;
    logic [15:0] mem_addr_q;
    logic        wr_en_q;
    logic [7:0]  wr_data_q;
    logic        rd_en_q;

    logic [7:0]  byte_w;
    logic        user_hit_w;
    logic        tcmd_hit_w;
    logic        busy_w;
    logic [15:0] rd_addr_inc_w;

    // Byte as it stands once the current bit is shifted in; complete at k=1.
    assign byte_w     = {shift_q, iic_sda_in};
    assign user_hit_w = (byte_w[7:1] == iic_dev_id);
    assign tcmd_hit_w = (byte_w[7:1] == TCMD_ID);
    // IDLE and WAIT ignore the bus until the next START.
    assign busy_w     = (state_q != ST_IDLE) && (state_q != ST_WAIT);

    // Sequential read address step; narrow devices wrap within one byte.
    always_comb begin
        rd_addr_inc_w = mem_addr_q + 16'd1;
        if (ONE_BYTE_ADDR) begin
            rd_addr_inc_w = {8'h00, mem_addr_q[7:0] + 8'd1};
        end
    end

    // Frame sequencer: state, bit counter, shift register, command decode,
    // address tracking and one-cycle strobes, all registered.
    always_ff @(posedge iic_clk_c or negedge iic_frm_rst_n) begin
        if (!iic_frm_rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 4'd8;
            shift_q    <= 7'd0;
            user_val_q <= 1'b0;
            tcmd_val_q <= 1'b0;
            mem_addr_q <= 16'd0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= 8'd0;
            rd_en_q    <= 1'b0;
        end else begin
            // Strobes live for exactly the ack-slot cycle.
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            if (iic_start) begin
                // The START edge already samples command bit 7.
                state_q    <= ST_CMD;
                bit_cnt_q  <= 4'd7;
                shift_q    <= {6'd0, iic_sda_in};
                user_val_q <= 1'b0;
                tcmd_val_q <= 1'b0;
            end else if (iic_stop) begin
                state_q    <= ST_IDLE;
                bit_cnt_q  <= 4'd8;
                user_val_q <= 1'b0;
                tcmd_val_q <= 1'b0;
            end else if (busy_w) begin
                if (bit_cnt_q != 4'd0) begin
                    shift_q   <= byte_w[6:0];
                    bit_cnt_q <= bit_cnt_q - 4'd1;
                    if (bit_cnt_q == 4'd1) begin
                        // Last data bit: the full byte is on byte_w.
                        case (state_q)
                            ST_CMD: begin
                                user_val_q <= user_hit_w;
                                tcmd_val_q <= tcmd_hit_w;
                                // Read command: fetch the current address now.
                                rd_en_q    <= (user_hit_w | tcmd_hit_w) & byte_w[0];
                            end
                            ST_ADDR_HB: begin
                                if (!ONE_BYTE_ADDR) begin
                                    mem_addr_q[15:8] <= byte_w;
                                end
                            end
                            ST_ADDR_LB: begin
                                mem_addr_q[7:0] <= byte_w;
                            end
                            ST_BYTE_WR, ST_PAGE_WR: begin
                                wr_data_q <= byte_w;
                                wr_en_q   <= ~iic_hwp_val;
                            end
                            ST_DAT_RD: begin
                                // Prefetch the next byte while the master acks.
                                mem_addr_q <= rd_addr_inc_w;
                                rd_en_q    <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end else begin
                    // Ack slot: resolve where the frame goes next.
                    bit_cnt_q <= 4'd8;
                    case (state_q)
                        ST_CMD: begin
                            // shift_q[0] now holds the R/W bit.
                            if (!(user_val_q | tcmd_val_q)) begin
                                state_q <= ST_WAIT;
                            end else if (shift_q[0]) begin
                                state_q <= ST_DAT_RD;
                            end else if (ONE_BYTE_ADDR) begin
                                state_q <= ST_ADDR_LB;
                            end else begin
                                state_q <= ST_ADDR_HB;
                            end
                        end
                        ST_ADDR_HB: state_q <= ST_ADDR_LB;
                        ST_ADDR_LB: state_q <= ST_BYTE_WR;
                        ST_BYTE_WR, ST_PAGE_WR: begin
                            // Page roll-over: only the in-page bits advance.
                            mem_addr_q[PAGE_BITS-1:0] <=
                                mem_addr_q[PAGE_BITS-1:0] + PAGE_BITS'(1);
                            state_q <= ST_PAGE_WR;
                        end
                        ST_DAT_RD: begin
                            // Master NACK ends the read burst.
                            state_q <= iic_sda_in ? ST_WAIT : ST_DAT_RD;
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign iic_curr_state   = state_q;
    assign iic_bit_cnt      = bit_cnt_q;
    assign iic_bitcnt_is_0  = (bit_cnt_q == 4'd0);
    assign iic_cmd_user_val = user_val_q;
    assign iic_tcmd_val     = tcmd_val_q;
    assign iic_mem_addr     = ONE_BYTE_ADDR ? {8'h00, mem_addr_q[7:0]} : mem_addr_q;
    assign iic_wr_en        = wr_en_q;
    assign iic_wr_data      = wr_data_q;
    assign iic_rd_en        = rd_en_q;

endmodule
